mdu: RTL and testbench

Iterative multiply/divide unit for the execute stage. It sits beside `alu2`, is fed from the same Operand1/Operand2 bus, and replaces the ALU's temporary `*` and `/` opcodes (E/F). Its result and flags are muxed into writeback when the instruction is an MDU op. The unit computes one operation at a time using a radix-2 shift-add/shift-subtract datapath and signals completion with a one-cycle valid pulse.

---
 rtl/mdu.sv | 168 ++++++++++++++++
 tb/tb_mdu.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu: iterative multiply/divide unit for the execute stage.
//
// One operation at a time on a radix-2 datapath. Multiply is shift-add, divide
// is restoring shift-subtract. Each takes XLEN iterations. Divide by zero skips
// the iterations and completes in a single cycle.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_start      request, sampled only while o_ready=1
//   i_operation  00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   i_operand1   multiplicand / dividend
//   i_operand2   multiplier / divisor
//   i_flush      abandons any operation in flight and ignores i_start
//   o_ready      unit can accept i_start this cycle
//   o_valid      one-cycle pulse: o_result/o_flags hold a new value
//   o_result     selected result, registered and held until the next completion
//   o_flags      [0] zero, [1] negative, [2] divide by zero, [3] MUL overflow
// ---------------------------------------------------------------------------
module mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_operation,
    input  logic [XLEN-1:0] i_operand1,
    input  logic [XLEN-1:0] i_operand2,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [3:0]      o_flags
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_opnd;    // multiplicand (mul) or divisor (div)
    // mul: {product high, multiplier / product low}
    // div: {remainder, dividend / quotient}
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_result;
    logic [3:0]        r_flags;

    logic              w_accept;
    logic              w_div_zero;
    logic              w_last;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN+1:0]   w_diff;
    logic              w_borrow;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_acc_step;
    logic [XLEN-1:0]   w_res_sel;
    logic [3:0]        w_flags_sel;
    logic [XLEN-1:0]   w_dz_result;
    logic [3:0]        w_dz_flags;

    assign w_accept   = i_start & ~i_flush & (r_state != StRun);
    assign w_div_zero = i_operation[1] & (i_operand2 == '0);
    assign w_last     = (r_state == StRun) && (r_count == CW'(XLEN - 1));

    // Multiply step: conditional add into the high half, carry shifts into the MSB.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide step: the remainder stays below the divisor, so the shifted value fits
    // in XLEN+1 bits. The extra difference bit is the borrow.
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opnd};
    assign w_borrow   = w_diff[XLEN+1];
    assign w_div_next = w_borrow ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                 : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_acc_step = r_op[1] ? w_div_next : w_mul_next;

    // Both layouts keep the MULHU/REMU result in the high half.
    assign w_res_sel   = r_op[0] ? w_acc_step[2*XLEN-1:XLEN] : w_acc_step[XLEN-1:0];
    assign w_flags_sel = {(r_op == 2'b00) && (w_acc_step[2*XLEN-1:XLEN] != '0),
                          1'b0,
                          w_res_sel[XLEN-1],
                          (w_res_sel == '0)};

    assign w_dz_result = i_operation[0] ? i_operand1 : '1;
    assign w_dz_flags  = {1'b0, 1'b1, w_dz_result[XLEN-1], (w_dz_result == '0)};

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_accept) begin
                        w_state_next = w_div_zero ? StDone : StRun;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
                StRun: begin
                    if (w_last) begin
                        w_state_next = StDone;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (!i_flush) begin
            if (w_accept) begin
                r_op    <= i_operation;
                r_opnd  <= i_operation[1] ? i_operand2 : i_operand1;
                r_acc   <= i_operation[1] ? {{XLEN{1'b0}}, i_operand1}
                                          : {{XLEN{1'b0}}, i_operand2};
                r_count <= '0;
                if (w_div_zero) begin
                    r_result <= w_dz_result;
                    r_flags  <= w_dz_flags;
                end
            end else if (r_state == StRun) begin
                r_acc   <= w_acc_step;
                r_count <= r_count + CW'(1);
                if (w_last) begin
                    r_result <= w_res_sel;
                    r_flags  <= w_flags_sel;
                end
            end
        end
    end

    assign o_ready  = (r_state != StRun);
    assign o_valid  = (r_state == StDone);
    assign o_result = r_result;
    assign o_flags  = r_flags;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu: self-checking bench for mdu.
//
// A cycle-level reference model tracks busy time, pending results and flags.
// It computes the arithmetic with plain 64-bit operators. One compare process
// checks every DUT output against the model on each falling edge. Directed
// cases carry hand-computed literal expectations. Randomized cases use the
// reference function.
// ---------------------------------------------------------------------------
module tb_mdu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  operation;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        flush;
    logic        ready;
    logic        valid;
    logic [31:0] result;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    mdu #(.XLEN(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_operation (operation),
        .i_operand1  (operand1),
        .i_operand2  (operand2),
        .i_flush     (flush),
        .o_ready     (ready),
        .o_valid     (valid),
        .o_result    (result),
        .o_flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {overflow, divzero, negative, zero, result}
    function automatic logic [35:0] ref_calc(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        p  = {32'd0, a} * {32'd0, b};
        dz = 1'b0;
        ov = 1'b0;
        case (op)
            2'd0: begin
                r  = p[31:0];
                ov = (p[63:32] != 32'd0);
            end
            2'd1: r = p[63:32];
            2'd2: begin
                if (b == 32'd0) begin
                    r  = 32'hFFFF_FFFF;
                    dz = 1'b1;
                end else begin
                    r = a / b;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    r  = a;
                    dz = 1'b1;
                end else begin
                    r = a % b;
                end
            end
        endcase
        return {ov, dz, r[31], (r == 32'd0), r};
    endfunction

    // Reference model: m_left counts the busy cycles remaining before completion
    logic [5:0]  m_left  = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_res   = '0;
    logic [3:0]  m_flg   = '0;
    logic [31:0] m_pres  = '0;
    logic [3:0]  m_pflg  = '0;
    logic [35:0] m_calc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= '0;
            m_valid <= 1'b0;
            m_res   <= '0;
            m_flg   <= '0;
        end else if (flush) begin
            m_left  <= '0;
            m_valid <= 1'b0;
        end else if (m_left != 0) begin
            m_left  <= m_left - 6'd1;
            m_valid <= (m_left == 6'd1);
            if (m_left == 6'd1) begin
                m_res <= m_pres;
                m_flg <= m_pflg;
            end
        end else begin
            m_valid <= 1'b0;
            if (start) begin
                m_calc = ref_calc(operation, operand1, operand2);
                if (operation[1] && operand2 == 32'd0) begin
                    m_valid <= 1'b1;
                    m_res   <= m_calc[31:0];
                    m_flg   <= m_calc[35:32];
                end else begin
                    m_left <= 6'd32;
                    m_pres <= m_calc[31:0];
                    m_pflg <= m_calc[35:32];
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_ready", ready, (m_left == 0));
        chk("cyc_valid", valid, m_valid);
        chk("cyc_result", result, m_res);
        chk("cyc_flags", flags, m_flg);
    end

    // Issue one op and wait for its completion. Latency counts edges after the
    // acceptance edge: 32 for iterative ops, 0 for divide by zero.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef, input bit mid_start);
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        operation = op;
        operand1  = a;
        operand2  = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        // Operand changes during the run must not matter.
        operand1  = $urandom;
        operand2  = $urandom;
        operation = 2'($urandom_range(0, 3));
        n = 0;
        while (!valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            start = (mid_start && n == 5);
        end
        start = 1'b0;
        chk("latency", n, (op[1] && b == 32'd0) ? 0 : 32);
        chk("op_result", result, er);
        chk("op_flags", flags, ef);
        chk("done_ready", ready, 1'b1);
    endtask

    task automatic rand_op(input bit mid_start);
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] e;
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
        endcase
        if ($urandom_range(0, 7) == 0) a = 32'd0;
        e = ref_calc(op, a, b);
        do_op(op, a, b, e[31:0], e[35:32], mid_start);
    endtask

    logic [31:0] saved_res;
    logic [3:0]  saved_flg;
    logic [35:0] exp_a;
    logic [35:0] exp_b;
    bit          seen_valid;
    int          n;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        operation = 2'd0;
        operand1  = '0;
        operand2  = '0;
        #1;
        chk("reset_ready", ready, 1'b1);
        chk("reset_valid", valid, 1'b0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", flags, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Hand-computed cases that pin the model and the DUT
        do_op(2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1001, 1'b0);
        do_op(2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 4'b0000, 1'b0);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0010, 1'b0);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b1000, 1'b1);
        do_op(2'd2, 32'd100, 32'd7, 32'd14, 4'b0000, 1'b0);
        do_op(2'd3, 32'd100, 32'd7, 32'd2, 4'b0000, 1'b0);
        do_op(2'd2, 32'h8000_0000, 32'd1, 32'h8000_0000, 4'b0010, 1'b0);
        do_op(2'd2, 32'h1234, 32'd0, 32'hFFFF_FFFF, 4'b0110, 1'b0);
        do_op(2'd3, 32'h1234, 32'd0, 32'h0000_1234, 4'b0100, 1'b0);
        do_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 4'b0000, 1'b0);

        // Flush in mid-run
        saved_res = result;
        saved_flg = flags;
        operation = 2'd2;
        operand1  = $urandom;
        operand2  = $urandom | 32'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        chk("flush_ready", ready, 1'b1);
        chk("flush_valid", valid, 1'b0);
        chk("flush_result", result, saved_res);
        chk("flush_flags", flags, saved_flg);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) seen_valid = 1'b1;
        end
        chk("flush_no_valid", seen_valid, 1'b0);

        // Asynchronous reset in mid-run
        operation = 2'd0;
        operand1  = $urandom | 32'h8000_0000;
        operand2  = $urandom | 32'h8000_0000;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", ready, 1'b1);
        chk("arst_valid", valid, 1'b0);
        chk("arst_result", result, 32'd0);
        chk("arst_flags", flags, 4'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) seen_valid = 1'b1;
        end
        chk("arst_no_valid", seen_valid, 1'b0);

        // Back-to-back with start held high
        operation = 2'd2;
        operand1  = $urandom;
        operand2  = $urandom_range(1, 1000);
        exp_a     = ref_calc(operation, operand1, operand2);
        start     = 1'b1;
        @(posedge clk);
        #1;
        operation = 2'd0;
        operand1  = $urandom;
        operand2  = $urandom;
        exp_b     = ref_calc(operation, operand1, operand2);
        n = 0;
        while (!valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_lat1", n, 32);
        chk("b2b_res1", result, exp_a[31:0]);
        chk("b2b_flg1", flags, exp_a[35:32]);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
        end while (!valid && n < 50);
        chk("b2b_gap", n, 33);
        chk("b2b_res2", result, exp_b[31:0]);
        chk("b2b_flg2", flags, exp_b[35:32]);

        // Randomized ops, some with stray start pulses in mid-run
        for (int i = 0; i < 40; i++) begin
            rand_op(($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
